router_fifo_pkt: RTL
====================

Name: router_fifo_pkt

Overview:
- Parametrised packet-aware FIFO, the next generation of the per-port router FIFO in the 1x3 router.
- Sits between the register/synchronizer stage and each output port.
- Stores {lfd, data} words and tracks packet boundaries on both sides, from the header length field.
- Adds occupancy count, almost-full, complete-packet count, registered SOP/EOP/valid read outputs and a sticky overflow flag.

Parameters:
- WIDTH, 8: data word width. Header layout is {payload_len[WIDTH-1:2], addr[1:0]}. WIDTH must be at least 4.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AFULL_LVL, 14: almost_full asserts when count >= AFULL_LVL.
- CW, $clog2(DEPTH)+1: count width (derived, not overridden).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- soft_reset  in  1  synchronous clear, active high (timeout recovery from the FSM).
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  marks data_in as a header word.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  data_out holds a word popped on the previous edge.
- sop  out  1  data_out is a header word (stored lfd = 1).
- eop  out  1  data_out is the parity word (last word of the packet).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  CW  current occupancy.
- pkt_count  out  CW  number of complete packets (header through parity) stored and not yet fully read.
- overflow_err  out  1  sticky: set by a write attempted while full.

Behaviour:
- Reset (resetn low, asynchronous):
  - Pointers, count, pkt_count, write and read packet counters, data_out, data_valid, sop, eop and overflow_err all go to 0.
  - empty = 1, full = 0.
  - Memory contents are don't-care.
- soft_reset = 1 at an edge:
  - Same clear as reset, including overflow_err.
  - soft_reset has priority over read_enb and write_enb in the same cycle.
- Write: accepted when write_enb = 1 and full = 0 (full sampled before the edge).
  - Stores {lfd_state, data_in} at the write pointer; the write pointer wraps modulo DEPTH.
  - write_enb with full = 1: word dropped, overflow_err set, pointers unchanged.
  - This holds even if a read happens in the same cycle.
- Read: accepted when read_enb = 1 and empty = 0 (empty sampled before the edge).
  - Next edge: data_out = stored data, data_valid = 1, sop = stored lfd, eop = read-side end flag.
  - Read latency is one clock.
  - No accepted read: data_valid, sop and eop go to 0 and data_out holds its last value.
  - read_enb while empty is ignored; it is not an error.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
  - When empty, only the write is accepted.
  - When full, only the read is accepted.
- Write-side packet tracking:
  - On an accepted write with lfd_state = 1: load wcnt = data_in[WIDTH-1:2] + 1 (payload words plus parity).
  - On each accepted non-header write with wcnt != 0: decrement wcnt. The write that takes wcnt from 1 to 0 completes a packet and increments pkt_count.
  - A header written while wcnt != 0 abandons the previous packet without counting it, and reloads wcnt.
  - Payload length 0 is legal: the packet is header plus parity, 2 words.
- Read-side packet tracking:
  - Reading a header loads rcnt = stored_len + 1.
  - Each later read decrements rcnt. The read taking rcnt from 1 to 0 sets eop and decrements pkt_count.
  - If pkt_count is incremented and decremented in the same edge, it is unchanged.
- Words read while rcnt == 0 that are not headers (orphans) pop normally with sop = eop = 0.

Test Plan:
- Reset/soft reset: after resetn pulse, then soft_reset pulse -> empty = 1, full = 0, count = 0, pkt_count = 0, data_valid = 0, overflow_err = 0.
- Full packet fill: header 0x39 (len 14, addr 01), 14 random payload words, parity; DEPTH = 16.
  - After the 14th word: count = 14, almost_full = 1.
  - After parity: full = 1, count = 16, pkt_count = 1.
- Drain the 16 words with read_enb held:
  - First valid output is 0x39 with sop = 1.
  - The 16th has eop = 1; pkt_count drops to 0 on that edge.
  - empty = 1; data_valid falls one cycle after the last pop; data_out matches write order.
- Overflow: with the FIFO full, write 0xAA -> count stays 16, overflow_err = 1 and sticky until soft_reset; 0xAA is never read out.
- Simultaneous read and write at count = 8 for 20 cycles -> count stays 8, pointers wrap, data order preserved.
  - At empty, read+write -> count = 1, data_valid = 0 next cycle.
- Zero-length packet: header 0x02 then parity 0x55 -> pkt_count = 1.
  - Read back: sop on 0x02, eop on 0x55.

Source files
------------

// File: rtl/router_fifo_pkt_if.sv
// Handshake and status bundle between a router FIFO and its producer/consumer.
// Modport slave is the FIFO side; master is the driving (FSM/port) side.
interface router_fifo_pkt_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             sop;
    logic             eop;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic [CW-1:0]    pkt_count;
    logic             overflow_err;

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, sop, eop, full, empty, almost_full,
               count, pkt_count, overflow_err
    );

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, sop, eop, full, empty, almost_full,
               count, pkt_count, overflow_err
    );
endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: stores {lfd, data}, tracks packet boundaries
// from the header length field on both sides, registered SOP/EOP/valid read port.
module router_fifo_pkt #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    router_fifo_pkt_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = WIDTH - 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pkt_count_q, pkt_count_d;
    logic [LW-1:0]    wcnt_q, wcnt_d;
    logic [LW-1:0]    rcnt_q, rcnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             overflow_q, overflow_d;

    logic             is_full, is_empty;
    logic             wr_acc, rd_acc, mem_we;
    logic             pkt_inc, pkt_dec;
    logic [WIDTH:0]   rd_word;

    always_comb begin
        is_full  = (count_q == CW'(DEPTH));
        is_empty = (count_q == '0);
        wr_acc   = bus.write_enb & ~is_full;
        rd_acc   = bus.read_enb & ~is_empty;
        mem_we   = wr_acc & ~bus.soft_reset;
        rd_word  = mem_q[rd_ptr_q];

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pkt_count_d  = pkt_count_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        overflow_d   = overflow_q;
        pkt_inc      = 1'b0;
        pkt_dec      = 1'b0;

        if (bus.write_enb && is_full) begin
            overflow_d = 1'b1;
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (bus.lfd_state) begin
                wcnt_d = {1'b0, bus.data_in[WIDTH-1:2]} + LW'(1);
            end else if (wcnt_q != '0) begin
                wcnt_d  = wcnt_q - LW'(1);
                pkt_inc = (wcnt_q == LW'(1));
            end
        end

        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            data_out_d   = rd_word[WIDTH-1:0];
            data_valid_d = 1'b1;
            sop_d        = rd_word[WIDTH];
            if (rd_word[WIDTH]) begin
                rcnt_d = {1'b0, rd_word[WIDTH-1:2]} + LW'(1);
            end else if (rcnt_q != '0) begin
                rcnt_d  = rcnt_q - LW'(1);
                eop_d   = (rcnt_q == LW'(1));
                pkt_dec = eop_d;
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pkt_inc && !pkt_dec) begin
            pkt_count_d = pkt_count_q + CW'(1);
        end else if (pkt_dec && !pkt_inc) begin
            pkt_count_d = pkt_count_q - CW'(1);
        end

        // soft_reset overrides every update above, including the sticky overflow
        if (bus.soft_reset) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pkt_count_d  = '0;
            wcnt_d       = '0;
            rcnt_d       = '0;
            data_out_d   = '0;
            data_valid_d = 1'b0;
            sop_d        = 1'b0;
            eop_d        = 1'b0;
            overflow_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_count_q  <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_count_q  <= pkt_count_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.sop          = sop_q;
    assign bus.eop          = eop_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (count_q >= CW'(AFULL_LVL));
    assign bus.count        = count_q;
    assign bus.pkt_count    = pkt_count_q;
    assign bus.overflow_err = overflow_q;

endmodule
